// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with 2-entry decode queue and redirect squash
//
// Purpose:
//   Owns the PC, issues in-order reads to instruction memory under a two-credit
//   scheme, buffers returned words in a 2-entry queue and presents the head of
//   that queue to decode with a valid/stall handshake. Redirects from later
//   stages flush the queue and squash responses to wrong-path requests.
//
// Optional feature macro: FETCH_PERF_COUNTERS_EN
//   defined   : stall_cycles / flush_count performance counters are built
//   undefined : both counter outputs are tied to zero
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   i_mem_ready    in   memory accepts a request this cycle
//   i_mem_read     out  request strobe (combinational)
//   i_mem_address  out  request address (current PC)
//   i_mem_valid    in   response valid, responses in request order
//   i_mem_data     in   response instruction word
//   redirect       in   taken branch/jump, flush and restart
//   redirect_PC    in   new fetch address
//   decode_stall   in   decode cannot accept this cycle
//   inst_valid     out  head-of-queue entry valid
//   instruction    out  head-of-queue instruction
//   inst_PC        out  PC of head-of-queue instruction
//   stall_cycles   out  cycles with inst_valid && decode_stall
//   flush_count    out  number of redirects
module fetch_unit #(
   parameter int                        CORE         = 0,
   parameter int                        DATA_WIDTH   = 32,
   parameter int                        ADDRESS_BITS = 20,
   parameter logic [ADDRESS_BITS-1:0]   RESET_PC     = '0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    i_mem_ready,
   output logic                    i_mem_read,
   output logic [ADDRESS_BITS-1:0] i_mem_address,
   input  logic                    i_mem_valid,
   input  logic [DATA_WIDTH-1:0]   i_mem_data,
   input  logic                    redirect,
   input  logic [ADDRESS_BITS-1:0] redirect_PC,
   input  logic                    decode_stall,
   output logic                    inst_valid,
   output logic [DATA_WIDTH-1:0]   instruction,
   output logic [ADDRESS_BITS-1:0] inst_PC,
   output logic [31:0]             stall_cycles,
   output logic [31:0]             flush_count
);

   logic [ADDRESS_BITS-1:0] pc_q, pc_d;
   logic [1:0]              count_q, count_d;
   logic [1:0]              outstanding_q, outstanding_d;
   logic [1:0]              drop_q, drop_d;
   logic                    q_rd_q, q_rd_d;
   logic                    q_wr_q, q_wr_d;
   logic                    tag_rd_q, tag_rd_d;
   logic                    tag_wr_q, tag_wr_d;

   logic [DATA_WIDTH-1:0]   q_data_q [2];
   logic [ADDRESS_BITS-1:0] q_pc_q   [2];
   logic [ADDRESS_BITS-1:0] tag_q    [2];

   logic resp_ok;
   logic issue;
   logic push;
   logic pop;

   // A response with nothing outstanding is a protocol violation; ignore it.
   assign resp_ok = i_mem_valid && (outstanding_q != 2'd0);

   // Credits cover both queued words and in-flight requests, so a response
   // always has a queue slot. Reset gates the strobe so nothing is requested
   // while the block is held in reset.
   assign issue = reset && i_mem_ready && !redirect &&
                  (({1'b0, count_q} + {1'b0, outstanding_q}) < 3'd2);

   // Wrong-path responses (drop_q != 0) are consumed without being queued.
   assign push = resp_ok && !redirect && (drop_q == 2'd0);
   assign pop  = (count_q != 2'd0) && !decode_stall && !redirect;

   assign i_mem_read    = issue;
   assign i_mem_address = pc_q;
   assign inst_valid    = (count_q != 2'd0);
   assign instruction   = q_data_q[q_rd_q];
   assign inst_PC       = q_pc_q[q_rd_q];

   always_comb begin
      pc_d          = pc_q;
      count_d       = count_q;
      drop_d        = drop_q;
      q_rd_d        = q_rd_q;
      q_wr_d        = q_wr_q;
      tag_rd_d      = tag_rd_q;
      tag_wr_d      = tag_wr_q;
      outstanding_d = outstanding_q + {1'b0, issue} - {1'b0, resp_ok};

      // Every request PC is tagged, including wrong-path ones, so the tag
      // FIFO stays aligned with the response stream across redirects.
      if (issue)   tag_wr_d = ~tag_wr_q;
      if (resp_ok) tag_rd_d = ~tag_rd_q;

      if (redirect) begin
         pc_d    = redirect_PC;
         count_d = 2'd0;
         q_rd_d  = 1'b0;
         q_wr_d  = 1'b0;
         // Everything still in flight after this cycle belongs to the old
         // path; a response arriving now is discarded outright.
         drop_d  = outstanding_q - {1'b0, resp_ok};
      end else begin
         if (issue) pc_d = pc_q + ADDRESS_BITS'(4);
         if (resp_ok && (drop_q != 2'd0)) drop_d = drop_q - 2'd1;
         if (push) q_wr_d = ~q_wr_q;
         if (pop)  q_rd_d = ~q_rd_q;
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q          <= RESET_PC;
         count_q       <= 2'd0;
         outstanding_q <= 2'd0;
         drop_q        <= 2'd0;
         q_rd_q        <= 1'b0;
         q_wr_q        <= 1'b0;
         tag_rd_q      <= 1'b0;
         tag_wr_q      <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         q_rd_q        <= q_rd_d;
         q_wr_q        <= q_wr_d;
         tag_rd_q      <= tag_rd_d;
         tag_wr_q      <= tag_wr_d;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            q_data_q[i] <= '0;
            q_pc_q[i]   <= '0;
            tag_q[i]    <= '0;
         end
      end else begin
         if (push) begin
            q_data_q[q_wr_q] <= i_mem_data;
            q_pc_q[q_wr_q]   <= tag_q[tag_rd_q];
         end
         if (issue) tag_q[tag_wr_q] <= pc_q;
      end
   end

`ifdef FETCH_PERF_COUNTERS_EN
   logic [31:0] stall_cycles_q;
   logic [31:0] flush_count_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_cycles_q <= 32'd0;
         flush_count_q  <= 32'd0;
      end else begin
         if ((count_q != 2'd0) && decode_stall) stall_cycles_q <= stall_cycles_q + 32'd1;
         if (redirect)                          flush_count_q  <= flush_count_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`else
   assign stall_cycles = 32'd0;
   assign flush_count  = 32'd0;
`endif

   a_resp_with_credit: assert property (@(posedge clock) disable iff (!reset)
      i_mem_valid |-> (outstanding_q != 2'd0))
      else $error("fetch_unit core %0d: response with nothing outstanding", CORE);

endmodule
